// File: rtl/uart_rom_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_rom_loader_pkg
// Shared constants for the UART ROM loader: frame sync bytes, the framing FSM
// state encoding and the byte-receiver state encoding.
// -----------------------------------------------------------------------------
package uart_rom_loader_pkg;

    // Frame preamble bytes
    localparam logic [7:0] SYNC0 = 8'h55;
    localparam logic [7:0] SYNC1 = 8'hAA;

    // Framing FSM encoding
    localparam logic [2:0] ST_IDLE_ENC = 3'd0;
    localparam logic [2:0] ST_HDR_ENC  = 3'd1;
    localparam logic [2:0] ST_LEN0_ENC = 3'd2;
    localparam logic [2:0] ST_LEN1_ENC = 3'd3;
    localparam logic [2:0] ST_DATA_ENC = 3'd4;
    localparam logic [2:0] ST_CSUM_ENC = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_HDR  = ST_HDR_ENC,
        ST_LEN0 = ST_LEN0_ENC,
        ST_LEN1 = ST_LEN1_ENC,
        ST_DATA = ST_DATA_ENC,
        ST_CSUM = ST_CSUM_ENC
    } loader_state_e;

    // Byte receiver encoding
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rom_loader_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// 8N1 UART byte receiver: 2-flop synchroniser, start-bit qualification at half
// a bit, data sampling at bit centres, stop-bit check.
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset
//   rx_i           raw serial line (idle high)
//   rx_valid_o     1-cycle strobe, rx_data_o holds the received byte
//   rx_data_o      received byte (LSB first on the line)
//   rx_ferr_o      1-cycle strobe when the stop bit sampled low
// -----------------------------------------------------------------------------
module uart_byte_rx
    import uart_rom_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       rx_ferr_o
);

    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic [1:0] sync_q;
    logic       prev_q;
    logic       rx_s;
    rx_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q;
    logic       valid_q;
    logic       ferr_q;
    logic [7:0] data_q;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchroniser resets to the idle line level so reset release
            // cannot look like a start bit.
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_s;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (prev_q && !rx_s) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    // Re-check the line mid start bit; a short glitch is dropped.
                    if (cnt_q == CW'(HALF - 1)) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? RX_IDLE : RX_BITS;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_BITS: begin
                    if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_s) begin
                            valid_q <= 1'b1;
                            data_q  <= shift_q;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_valid_o = valid_q;
    assign rx_data_o  = data_q;
    assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/uart_rom_loader.sv
// -----------------------------------------------------------------------------
// uart_rom_loader
// Receives a framed program image over UART (55 AA LEN_lo LEN_hi data.. CSUM),
// assembles little-endian 32-bit words and writes them to the ROM write port.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   uart_rx_i    serial input, 8N1
//   wr_en_o      one-cycle ROM write strobe per word
//   wr_addr_o    word-aligned ROM byte address (held between writes)
//   wr_data_o    ROM write data (held between writes)
//   busy_o       frame in progress; core must be held in reset
//   done_o       last frame completed with good checksum (sticky)
//   err_o        last frame aborted (sticky)
// -----------------------------------------------------------------------------
module uart_rom_loader
    import uart_rom_loader_pkg::*;
#(
    parameter int          CLK_FREQ    = 50_000_000,
    parameter int          BAUD        = 115200,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MAX_WORDS   = 32,
    parameter int          TIMEOUT_CYC = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx_i,
    output logic        wr_en_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int          KW           = $clog2(MAX_WORDS + 1);
    localparam int          TW           = $clog2(TIMEOUT_CYC + 1);
    localparam logic [15:0] MAX_N        = 16'(MAX_WORDS);

    logic       rx_valid;
    logic       rx_ferr;
    logic [7:0] rx_data;

    uart_byte_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (uart_rx_i),
        .rx_valid_o (rx_valid),
        .rx_data_o  (rx_data),
        .rx_ferr_o  (rx_ferr)
    );

    loader_state_e state_q;
    logic [7:0]    len_lo_q;
    logic [KW-1:0] n_q;
    logic [KW-1:0] k_q;
    logic [1:0]    j_q;
    logic [23:0]   word_q;
    logic [7:0]    sum_q;
    logic [TW-1:0] to_cnt_q;
    logic [TW-1:0] to_cnt_d;
    logic          wr_en_q;
    logic [31:0]   wr_addr_q;
    logic [31:0]   wr_data_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [15:0]   len_full;
    logic          timeout_hit;

    assign len_full = {rx_data, len_lo_q};

    // The counter holds the number of clocks since the last rx_valid while a
    // frame is open; it expires on the TIMEOUT_CYC-th such clock, and that
    // expiry takes priority over a byte arriving in the same cycle.
    assign timeout_hit = (state_q != ST_IDLE) && (to_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (state_q == ST_IDLE || rx_valid) begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_lo_q  <= '0;
            n_q       <= '0;
            k_q       <= '0;
            j_q       <= '0;
            word_q    <= '0;
            sum_q     <= '0;
            to_cnt_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q  <= 1'b0;
            to_cnt_q <= to_cnt_d;
            if (timeout_hit || (rx_ferr && state_q != ST_IDLE)) begin
                state_q  <= ST_IDLE;
                err_q    <= 1'b1;
                done_q   <= 1'b0;
                busy_q   <= 1'b0;
                to_cnt_q <= '0;
            end else if (rx_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data == SYNC0) begin
                            state_q <= ST_HDR;
                            done_q  <= 1'b0;
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            sum_q   <= '0;
                            k_q     <= '0;
                            j_q     <= '0;
                        end
                    end
                    ST_HDR: begin
                        if (rx_data == SYNC1) begin
                            state_q <= ST_LEN0;
                        end else if (rx_data != SYNC0) begin
                            // Not a frame after all: back off silently.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_LEN0: begin
                        len_lo_q <= rx_data;
                        state_q  <= ST_LEN1;
                    end
                    ST_LEN1: begin
                        k_q <= '0;
                        j_q <= '0;
                        if (len_full == 16'd0) begin
                            n_q     <= '0;
                            state_q <= ST_CSUM;
                        end else if (len_full > MAX_N) begin
                            state_q <= ST_IDLE;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            n_q     <= len_full[KW-1:0];
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        sum_q <= sum_q + rx_data;
                        j_q   <= j_q + 2'd1;
                        case (j_q)
                            2'd0: word_q[7:0]   <= rx_data;
                            2'd1: word_q[15:8]  <= rx_data;
                            2'd2: word_q[23:16] <= rx_data;
                            default: begin
                                // Top byte completes the word: write it now.
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= BASE_ADDR + 32'({k_q, 2'b00});
                                wr_data_q <= {rx_data, word_q};
                                k_q       <= k_q + KW'(1);
                                if (k_q == n_q - KW'(1)) begin
                                    state_q <= ST_CSUM;
                                end
                            end
                        endcase
                    end
                    ST_CSUM: begin
                        if (rx_data == sum_q) begin
                            done_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_rom_loader
// Drives UART frames into uart_rom_loader. Expected ROM writes are queued when
// a frame is built; a monitor pops and compares each wr_en_o pulse. Frame
// status is predicted from the frame contents (length limit, byte sum).
// -----------------------------------------------------------------------------
module tb_uart_rom_loader;

    localparam int          CLK_FREQ    = 1_000_000;
    localparam int          BAUD        = 100_000;
    localparam int          CPB         = CLK_FREQ / BAUD;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
    localparam int          MAX_WORDS   = 32;
    localparam int          TIMEOUT_CYC = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    uart_rom_loader #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .BASE_ADDR   (BASE_ADDR),
        .MAX_WORDS   (MAX_WORDS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx_i (uart_rx),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    int valid_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next queued write.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h expected no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                $display("write addr=%h data=%h (expected %h %h)", wr_addr, wr_data, e.addr, e.data);
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
            end
        end
    end

    // Time reference for the timeout measurement and the glitch check.
    always @(negedge clk) begin
        if (dut.u_rx.rx_valid_o) begin
            last_valid_cyc = cyc;
            valid_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            send_byte(bytes[i], 1'b1);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
    endtask

    // Reference: a frame is accepted when N <= MAX_WORDS and the checksum byte
    // equals the sum of the data bytes mod 256; each word lands at BASE+4*k.
    task automatic send_frame(input logic [31:0] words[$], input bit corrupt, output bit exp_done);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        int n;
        n = words.size();
        sum = 8'h00;
        bytes = {8'h55, 8'hAA, 8'(n), 8'(n >> 8)};
        foreach (words[i]) begin
            for (int b = 0; b < 4; b++) begin
                bytes.push_back(8'(words[i] >> (8 * b)));
                sum = sum + 8'(words[i] >> (8 * b));
            end
            exp_q.push_back('{addr: BASE_ADDR + 32'(4 * i), data: words[i]});
        end
        bytes.push_back(corrupt ? sum + 8'h01 : sum);
        send_bytes(bytes);
        exp_done = !corrupt;
    endtask

    task automatic check_status(input string name, input bit exp_done);
        repeat (3) @(negedge clk);
        $display("status %s: done=%0b err=%0b busy=%0b", name, done, err, busy);
        check({name, "_done"}, 32'(done), 32'(exp_done));
        check({name, "_err"}, 32'(err), 32'(!exp_done));
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        check({name, "_exclusive"}, 32'(done && err), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_wr_en"}, 32'(wr_en), 32'd0);
        check({name, "_wr_addr"}, wr_addr, 32'd0);
        check({name, "_wr_data"}, wr_data, 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w[$];
        bit          ed;
        int          v0;
        int          err_cyc;
        bit          err_seen;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Good frame from the fixed vector set.
        w = {32'h0000_0013, 32'h0010_0093};
        send_frame(w, 1'b0, ed);
        check_status("good", ed);

        // Same frame with checksum off by one.
        send_frame(w, 1'b1, ed);
        check_status("bad_csum", ed);

        // N=33 exceeds the ROM depth: rejected after LEN1 with no writes.
        send_bytes({8'h55, 8'hAA, 8'h21, 8'h00});
        check_status("over_limit", 1'b0);
        send_frame(w, 1'b0, ed);
        check_status("after_over_limit", ed);

        // Noise byte, repeated sync, empty frame with zero checksum.
        send_bytes({8'h12, 8'h55, 8'h55, 8'hAA, 8'h00, 8'h00, 8'h00});
        check_status("resync", 1'b1);

        // A 3-clock low glitch inside a header must not yield a byte.
        send_bytes({8'h55});
        v0 = valid_cnt;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_rx_valid_count", 32'(valid_cnt), 32'(v0));
        send_bytes({8'hAA, 8'h00, 8'h00, 8'h00});
        check_status("glitch", 1'b1);

        // Timeout: stall in DATA. rx_valid seen in cycle c is consumed at the
        // following edge; err rises TIMEOUT_CYC edges after that.
        send_bytes({8'h55, 8'hAA, 8'h01, 8'h00, 8'h13});
        err_seen = 1'b0;
        err_cyc = 0;
        for (int i = 0; i < TIMEOUT_CYC + 200; i++) begin
            @(negedge clk);
            if (err) begin
                err_seen = 1'b1;
                err_cyc = cyc;
                break;
            end
        end
        $display("timeout: err_seen=%0b at cycle %0d, last rx_valid cycle %0d", err_seen, err_cyc, last_valid_cyc);
        check("timeout_seen", 32'(err_seen), 32'd1);
        check("timeout_cycle", 32'(err_cyc), 32'(last_valid_cyc + 1 + TIMEOUT_CYC));
        check_status("timeout", 1'b0);

        // Framing error (stop bit low) during DATA.
        send_bytes({8'h55, 8'hAA, 8'h01, 8'h00, 8'h13});
        send_byte(8'h00, 1'b0);
        check_status("framing", 1'b0);

        // Reset mid-frame, away from a clock edge: outputs clear at once.
        send_bytes({8'h55, 8'hAA, 8'h02, 8'h00, 8'h13, 8'h00});
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(w, 1'b0, ed);
        check_status("after_reset", ed);

        // Randomised frames.
        for (int f = 0; f < 6; f++) begin
            int n;
            logic [31:0] rw[$];
            n = $urandom_range(1, 6);
            rw = {};
            for (int i = 0; i < n; i++) rw.push_back($urandom);
            send_frame(rw, ($urandom_range(0, 3) == 0), ed);
            check_status("random", ed);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
